// File: rtl/enc4to2_reg.sv
// Registered 4-to-2 encoder with enable, multi-hot flag and valid/ack handshake.
// Define ENC4TO2_REG_RR_EN for round-robin selection instead of highest-index priority.
module enc4to2_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in,
  input  logic       en,
  input  logic       ack,
  output logic [1:0] out,
  output logic       valid,
  output logic       multi
);

  // state | meaning
  // IDLE  | no result held, valid=0
  // HOLD  | result held in out/multi until ack, valid=1
  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state_q;
  logic [1:0] out_q;
  logic       multi_q;
  logic [1:0] sel_d;
  logic       multi_d;
  logic       cap;

  assign cap     = en && (in != 4'b0000) && ((state_q == IDLE) || ack);
  assign multi_d = |(in & (in - 4'd1));

`ifdef ENC4TO2_REG_RR_EN
  logic [1:0] last_q;

  // walk from last_q+4 down to last_q+1 so the nearest set bit after last_q wins
  always_comb begin
    sel_d = last_q;
    for (int k = 4; k >= 1; k--) begin
      if (in[last_q + 2'(k)]) sel_d = last_q + 2'(k);
    end
  end
`else
  always_comb begin
    sel_d = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (in[i]) sel_d = 2'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= 2'b00;
      multi_q <= 1'b0;
`ifdef ENC4TO2_REG_RR_EN
      last_q  <= 2'b11;
`endif
    end else if (cap) begin
      state_q <= HOLD;
      out_q   <= sel_d;
      multi_q <= multi_d;
`ifdef ENC4TO2_REG_RR_EN
      last_q  <= sel_d;
`endif
    end else if ((state_q == HOLD) && ack) begin
      state_q <= IDLE;
    end
  end

  assign out   = out_q;
  assign multi = multi_q;
  assign valid = (state_q == HOLD);

endmodule

// File: tb/tb_enc4to2_reg.sv
// Scoreboard bench for enc4to2_reg; expected results are queued when a capture is driven.
// Follows the ENC4TO2_REG_RR_EN build if that macro is defined.
module tb_enc4to2_reg;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_s;
  logic       en;
  logic       ack;
  logic [1:0] out;
  logic       valid;
  logic       multi;

  typedef struct packed {
    logic [1:0] o;
    logic       m;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         total;
  int         bad;
  logic       m_valid;
  logic [1:0] m_last;
  logic [1:0] m_out;
  logic       m_multi;
  logic       m_cap;
  logic [3:0] dec;

  enc4to2_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_s),
    .en    (en),
    .ack   (ack),
    .out   (out),
    .valid (valid),
    .multi (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] ref_sel(input logic [3:0] v);
    logic [1:0] r;
    r = 2'b00;
`ifdef ENC4TO2_REG_RR_EN
    begin
      bit found;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        logic [1:0] idx;
        idx = 2'((int'(m_last) + k) % 4);
        if (!found && v[idx]) begin
          r     = idx;
          found = 1'b1;
        end
      end
    end
`else
    if (v[3])      r = 2'd3;
    else if (v[2]) r = 2'd2;
    else if (v[1]) r = 2'd1;
    else           r = 2'd0;
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_last  = 2'b11;
    m_out   = 2'b00;
    m_multi = 1'b0;
    exp_q.delete();
  endtask

  // Apply one cycle of inputs at the falling edge, update the model, and return
  // at the next falling edge so outputs are sampled away from the active edge.
  task automatic drive(input logic e_i, input logic [3:0] v, input logic a);
    logic [1:0] s;
    en    = e_i;
    in_s  = v;
    ack   = a;
    m_cap = e_i && (v != 4'b0000) && (!m_valid || a);
    if (m_cap) begin
      s       = ref_sel(v);
      m_out   = s;
      m_multi = ($countones(v) > 1);
      m_last  = s;
      m_valid = 1'b1;
      exp_q.push_back('{o: s, m: m_multi});
    end else if (m_valid && a) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop_exp();
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: got size=0 required size>0");
      e = '{o: m_out, m: m_multi};
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    in_s  = 4'b0000;
    ack   = 1'b0;
    model_reset();
    #2;
    total++;
    if (out !== 2'b00) begin bad++; $display("FAIL reset_out: got=%b required=00", out); end
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%b required=0", valid); end
    total++;
    if (multi !== 1'b0) begin bad++; $display("FAIL reset_multi: got=%b required=0", multi); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_enable_gating();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'(1 << i), 1'b0);
      total++;
      if (valid !== 1'b0) begin bad++; $display("FAIL gate_valid[%0d]: got=%b required=0", i, valid); end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(1 << i), 1'b1);
      pop_exp();
      total++;
      if (out !== e.o || out !== 2'(i))
        begin bad++; $display("FAIL onehot_out[%0d]: got=%b required=%b", i, out, e.o); end
      total++;
      if (multi !== 1'b0) begin bad++; $display("FAIL onehot_multi[%0d]: got=%b required=0", i, multi); end
      total++;
      if (valid !== 1'b1) begin bad++; $display("FAIL onehot_valid[%0d]: got=%b required=1", i, valid); end
    end
  endtask

  task automatic test_hold_ack();
    drive(1'b1, 4'b0010, 1'b1);
    pop_exp();
    total++;
    if (out !== e.o) begin bad++; $display("FAIL hold_first_out: got=%b required=%b", out, e.o); end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'b1000, 1'b0);
      total++;
      if (out !== 2'b01) begin bad++; $display("FAIL hold_frozen_out[%0d]: got=%b required=01", c, out); end
      total++;
      if (valid !== 1'b1) begin bad++; $display("FAIL hold_frozen_valid[%0d]: got=%b required=1", c, valid); end
    end
    drive(1'b1, 4'b1000, 1'b1);
    pop_exp();
    total++;
    if (out !== e.o || out !== 2'b11) begin bad++; $display("FAIL hold_ack_out: got=%b required=%b", out, e.o); end
    total++;
    if (valid !== 1'b1) begin bad++; $display("FAIL hold_ack_valid: got=%b required=1", valid); end
    drive(1'b0, 4'b0000, 1'b1);
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL hold_release_valid: got=%b required=0", valid); end
  endtask

  task automatic test_multi();
    drive(1'b1, 4'b1011, 1'b0);
    pop_exp();
    total++;
    if (out !== e.o) begin bad++; $display("FAIL multi_out: got=%b required=%b", out, e.o); end
    total++;
    if (multi !== 1'b1) begin bad++; $display("FAIL multi_flag: got=%b required=1", multi); end
    drive(1'b1, 4'b0000, 1'b1);
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL multi_ack_valid: got=%b required=0", valid); end
    total++;
    if (out !== m_out) begin bad++; $display("FAIL multi_ack_out_kept: got=%b required=%b", out, m_out); end
    drive(1'b0, 4'b1111, 1'b1);
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL idle_ack_ignored: got=%b required=0", valid); end
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 4'b1111, 1'b1);
      pop_exp();
      total++;
      if (out !== e.o) begin bad++; $display("FAIL b2b_out[%0d]: got=%b required=%b", c, out, e.o); end
      total++;
      if (multi !== 1'b1 || valid !== 1'b1)
        begin bad++; $display("FAIL b2b_flags[%0d]: got multi=%b valid=%b required 1 1", c, multi, valid); end
    end
    drive(1'b0, 4'b0000, 1'b1);
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL b2b_drain_valid: got=%b required=0", valid); end
  endtask

  task automatic test_roundtrip();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(1 << i), 1'b0);
      pop_exp();
      dec = valid ? 4'(1 << out) : 4'b0000;
      total++;
      if (dec !== 4'(1 << i)) begin bad++; $display("FAIL roundtrip[%0d]: got=%b required=%b", i, dec, 4'(1 << i)); end
      drive(1'b0, 4'b0000, 1'b1);
      dec = valid ? 4'(1 << out) : 4'b0000;
      total++;
      if (dec !== 4'b0000) begin bad++; $display("FAIL roundtrip_idle[%0d]: got=%b required=0000", i, dec); end
    end
  endtask

  task automatic test_reset_mid_hold();
    drive(1'b1, 4'b0100, 1'b0);
    pop_exp();
    total++;
    if (out !== 2'b10 || valid !== 1'b1)
      begin bad++; $display("FAIL midhold_capture: got out=%b valid=%b required 10 1", out, valid); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (out !== 2'b00 || valid !== 1'b0 || multi !== 1'b0)
      begin bad++; $display("FAIL midhold_async_reset: got out=%b valid=%b multi=%b required 00 0 0", out, valid, multi); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'b1001, 1'b0);
    pop_exp();
    total++;
    if (out !== e.o || valid !== 1'b1 || multi !== 1'b1)
      begin bad++; $display("FAIL post_reset_capture: got out=%b valid=%b multi=%b required %b 1 1", out, valid, multi, e.o); end
    drive(1'b0, 4'b0000, 1'b1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_enable_gating();
    test_hold_ack();
    test_multi();
    test_back_to_back();
    test_roundtrip();
    test_reset_mid_hold();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover: got=%0d required=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
